// File: rtl/dsi_capture_ctrl.sv
// dsi_capture_ctrl
// Captures the first packet of each MIPI DSI high-speed burst from a two-lane
// byte-pair receiver and turns it into a 32-bit packet stream with sop/eop.
// The data type can be filtered, and capture can stop after a chosen number
// of packets. All stream outputs are registered, so a word reaches out_valid
// exactly one clock after it is presented on the lanes.

module dsi_capture_ctrl #(
  parameter int unsigned MAX_PKTS = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] lane0_data,
  input  logic [15:0] lane1_data,
  input  logic        capture_en,
  input  logic        arm,
  input  logic        abort,
  input  logic        dt_filter_en,
  input  logic [5:0]  dt_filter,
  input  logic [7:0]  pkt_target,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic [5:0]  hdr_dt,
  output logic [1:0]  hdr_vc,
  output logic [15:0] hdr_wc,
  output logic        busy,
  output logic        done,
  output logic        trunc_err,
  output logic [7:0]  pkt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_PAYLOAD = 3'd2,
    S_SKIP    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // Targets above MAX_PKTS are clamped; the port itself stays 8 bits wide.
  localparam logic [7:0] TARGET_LIMIT = (MAX_PKTS > 255) ? 8'hFF : 8'(MAX_PKTS);

  // Registered state
  state_e      state_q, state_d;
  logic        cap_en_q;
  logic [14:0] rem_q, rem_d;
  logic [7:0]  pkt_cnt_q, pkt_cnt_d;
  logic        trunc_q, trunc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [5:0]  hdr_dt_q, hdr_dt_d;
  logic [1:0]  hdr_vc_q, hdr_vc_d;
  logic [15:0] hdr_wc_q, hdr_wc_d;

  // Decoded view of the current input word
  logic [31:0] word;
  logic [5:0]  word_dt;
  logic [1:0]  word_vc;
  logic [15:0] word_wc;
  logic        word_is_long;
  logic        hdr_accept;
  logic        burst_start;
  logic [16:0] wc_plus2;
  logic [14:0] rem_load;
  logic [7:0]  cnt_inc;
  logic [7:0]  target_eff;
  logic        target_hit;

  // Reassemble the lane byte pairs into the stream word and decode its header.
  always_comb begin
    word         = {lane1_data[15:8], lane0_data[15:8], lane1_data[7:0], lane0_data[7:0]};
    word_dt      = word[5:0];
    word_vc      = word[7:6];
    word_wc      = word[23:8];
    word_is_long = (word_dt[3:0] == 4'h9) || (word_dt[3:0] == 4'hC) ||
                   (word_dt[3:0] == 4'hD) || (word_dt[3:0] == 4'hE);
    hdr_accept   = !dt_filter_en || (word_dt == dt_filter);
    burst_start  = capture_en && !cap_en_q;
    // Payload words after the header: ceil((WC + 2 CRC bytes) / 4), in 17 bits
    // so WC = 0xFFFF cannot wrap.
    wc_plus2     = {1'b0, word_wc} + 17'd2;
    rem_load     = wc_plus2[16:2] + {14'd0, |wc_plus2[1:0]};
  end

  // Saturating packet count and the effective capture target.
  always_comb begin
    cnt_inc    = (pkt_cnt_q == 8'hFF) ? 8'hFF : pkt_cnt_q + 8'd1;
    target_eff = (pkt_target > TARGET_LIMIT) ? TARGET_LIMIT : pkt_target;
    target_hit = (target_eff != 8'd0) && (pkt_cnt_q == target_eff);
  end

  // Next-state, stream and status logic for the capture FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    rem_d       = rem_q;
    pkt_cnt_d   = pkt_cnt_q;
    trunc_d     = trunc_q;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_eop_d   = 1'b0;
    out_data_d  = out_data_q;
    hdr_dt_d    = hdr_dt_q;
    hdr_vc_d    = hdr_vc_q;
    hdr_wc_d    = hdr_wc_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          pkt_cnt_d = 8'd0;
          trunc_d   = 1'b0;
          state_d   = S_ARMED;
        end
      end

      S_ARMED: begin
        // Only a fresh 0->1 edge of capture_en carries a header.
        if (burst_start) begin
          if (hdr_accept) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_data_d  = word;
            hdr_dt_d    = word_dt;
            hdr_vc_d    = word_vc;
            hdr_wc_d    = word_wc;
            if (word_is_long) begin
              rem_d   = rem_load;
              state_d = S_PAYLOAD;
            end else begin
              out_eop_d = 1'b1;
              pkt_cnt_d = cnt_inc;
              state_d   = S_SKIP;
            end
          end else begin
            state_d = S_SKIP;
          end
        end
      end

      S_PAYLOAD: begin
        if (capture_en) begin
          out_valid_d = 1'b1;
          out_data_d  = word;
          rem_d       = rem_q - 15'd1;
          if (rem_q == 15'd1) begin
            out_eop_d = 1'b1;
            pkt_cnt_d = cnt_inc;
            state_d   = S_SKIP;
          end
        end else begin
          // Burst ended before the payload did: flag it and wait for the next.
          trunc_d = 1'b1;
          state_d = S_ARMED;
        end
      end

      S_SKIP: begin
        if (!capture_en) begin
          state_d = target_hit ? S_DONE : S_ARMED;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort beats everything, including a simultaneous arm: nothing emitted,
    // counters and header left as they were.
    if (abort) begin
      state_d     = S_IDLE;
      pkt_cnt_d   = pkt_cnt_q;
      trunc_d     = trunc_q;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_data_d  = out_data_q;
      hdr_dt_d    = hdr_dt_q;
      hdr_vc_d    = hdr_vc_q;
      hdr_wc_d    = hdr_wc_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      cap_en_q    <= 1'b0;
      rem_q       <= 15'd0;
      pkt_cnt_q   <= 8'd0;
      trunc_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      hdr_dt_q    <= 6'd0;
      hdr_vc_q    <= 2'd0;
      hdr_wc_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cap_en_q    <= capture_en;
      rem_q       <= rem_d;
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_q     <= trunc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      hdr_dt_q    <= hdr_dt_d;
      hdr_vc_q    <= hdr_vc_d;
      hdr_wc_q    <= hdr_wc_d;
    end
  end

  // Status flags decoded straight from the state register.
  always_comb begin
    busy = (state_q == S_ARMED) || (state_q == S_PAYLOAD) || (state_q == S_SKIP);
    done = (state_q == S_DONE);
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign hdr_dt    = hdr_dt_q;
  assign hdr_vc    = hdr_vc_q;
  assign hdr_wc    = hdr_wc_q;
  assign trunc_err = trunc_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_dsi_capture_ctrl.sv
// Testbench for dsi_capture_ctrl: directed scenarios followed by random
// bursts, compared against a burst-level reference model.

module tb_dsi_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lane0_data, lane1_data;
  logic        capture_en, arm, abort, dt_filter_en;
  logic [5:0]  dt_filter;
  logic [7:0]  pkt_target;
  logic        out_valid, out_sop, out_eop, busy, done, trunc_err;
  logic [31:0] out_data;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic [7:0]  pkt_cnt;

  always #5 clk = ~clk;

  dsi_capture_ctrl #(.MAX_PKTS(255)) dut (
    .clk(clk), .reset(reset),
    .lane0_data(lane0_data), .lane1_data(lane1_data),
    .capture_en(capture_en), .arm(arm), .abort(abort),
    .dt_filter_en(dt_filter_en), .dt_filter(dt_filter), .pkt_target(pkt_target),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .hdr_dt(hdr_dt), .hdr_vc(hdr_vc), .hdr_wc(hdr_wc),
    .busy(busy), .done(done), .trunc_err(trunc_err), .pkt_cnt(pkt_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef enum {M_IDLE, M_ARMED, M_DONE} mmode_e;

  beat_t       got_q[$];
  beat_t       exp_q[$];
  logic [31:0] burst_q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: capture status tracked per burst, not per cycle.
  mmode_e      m_mode  = M_IDLE;
  int          m_cnt   = 0;
  bit          m_trunc = 1'b0;
  logic [5:0]  m_dt    = '0;
  logic [1:0]  m_vc    = '0;
  logic [15:0] m_wc    = '0;

  // Collect every emitted beat, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) got_q.push_back({out_data, out_sop, out_eop});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input logic [31:0] w);
    lane0_data = {w[23:16], w[7:0]};
    lane1_data = {w[31:24], w[15:8]};
  endtask

  function automatic logic [31:0] mk_hdr(input logic [5:0] dt, input logic [1:0] vc,
                                          input logic [15:0] wc, input logic [7:0] ecc);
    return {ecc, wc, vc, dt};
  endfunction

  function automatic bit dt_is_long(input logic [5:0] dt);
    return (dt[3:0] == 4'h9) || (dt[3:0] == 4'hC) || (dt[3:0] == 4'hD) || (dt[3:0] == 4'hE);
  endfunction

  function automatic int sat_inc(input int c);
    return (c < 255) ? c + 1 : 255;
  endfunction

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
    if (m_mode != M_ARMED) begin
      m_cnt   = 0;
      m_trunc = 1'b0;
      m_mode  = M_ARMED;
    end
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    step();
    abort = 1'b0;
    m_mode = M_IDLE;
  endtask

  // Predict what one complete burst (burst_q) produces.
  task automatic model_burst();
    logic [31:0] w0;
    logic [5:0]  dt;
    logic [15:0] wc;
    int          rem;
    int          n;
    bit          complete;
    if (m_mode != M_ARMED || burst_q.size() == 0) return;
    n        = burst_q.size();
    w0       = burst_q[0];
    dt       = w0[5:0];
    wc       = w0[23:8];
    complete = 1'b1;
    if (!dt_filter_en || dt == dt_filter) begin
      m_dt = dt;
      m_vc = w0[7:6];
      m_wc = wc;
      if (dt_is_long(dt)) begin
        rem = (int'(wc) + 2 + 3) / 4;
        exp_q.push_back({w0, 1'b1, 1'b0});
        for (int i = 1; i < n && i <= rem; i++)
          exp_q.push_back({burst_q[i], 1'b0, (i == rem)});
        if (n - 1 >= rem) m_cnt = sat_inc(m_cnt);
        else begin
          m_trunc  = 1'b1;
          complete = 1'b0;
        end
      end else begin
        exp_q.push_back({w0, 1'b1, 1'b1});
        m_cnt = sat_inc(m_cnt);
      end
    end
    if (complete && pkt_target != 8'd0 && m_cnt == int'(pkt_target)) m_mode = M_DONE;
  endtask

  task automatic run_burst(input int gap);
    model_burst();
    capture_en = 1'b1;
    foreach (burst_q[i]) begin
      set_word(burst_q[i]);
      step();
    end
    capture_en = 1'b0;
    set_word(32'd0);
    repeat (gap) step();
    burst_q.delete();
  endtask

  task automatic check_stream(input string tag);
    check({tag, ".beats"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s.beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_status(input string tag);
    check({tag, ".pkt_cnt"},   64'(pkt_cnt),   64'(m_cnt));
    check({tag, ".trunc_err"}, 64'(trunc_err), 64'(m_trunc));
    check({tag, ".done"},      64'(done),      64'(m_mode == M_DONE));
    check({tag, ".busy"},      64'(busy),      64'(m_mode == M_ARMED));
    check({tag, ".hdr_dt"},    64'(hdr_dt),    64'(m_dt));
    check({tag, ".hdr_vc"},    64'(hdr_vc),    64'(m_vc));
    check({tag, ".hdr_wc"},    64'(hdr_wc),    64'(m_wc));
  endtask

  initial begin
    logic [5:0]  dts [6];
    logic [5:0]  dt;
    logic [15:0] wc;
    int          rem;
    int          len;

    dts = '{6'h05, 6'h39, 6'h2C, 6'h1E, 6'h12, 6'h29};

    // Reset wins over arm and abort.
    reset = 1'b1; arm = 1'b1; abort = 1'b1; capture_en = 1'b0;
    dt_filter_en = 1'b0; dt_filter = 6'd0; pkt_target = 8'd0;
    set_word(32'd0);
    repeat (3) step();
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_sop",   64'(out_sop),   64'd0);
    check("rst.out_eop",   64'(out_eop),   64'd0);
    check("rst.out_data",  64'(out_data),  64'd0);
    check_status("rst");
    reset = 1'b0; arm = 1'b0; abort = 1'b0;
    step();
    check_status("idle");

    // Single short packet, target 1: one-cycle latency, then done.
    pkt_target = 8'd1;
    pulse_arm();
    check_status("r37.armed");
    burst_q.push_back(32'h1A000005);
    model_burst();
    capture_en = 1'b1;
    set_word(32'h1A000005);
    step();
    check("r37.valid", 64'(out_valid), 64'd1);
    check("r37.sop",   64'(out_sop),   64'd1);
    check("r37.eop",   64'(out_eop),   64'd1);
    check("r37.data",  64'(out_data),  64'h1A000005);
    capture_en = 1'b0;
    set_word(32'd0);
    burst_q.delete();
    step();
    check("r37.done", 64'(done), 64'd1);
    check_stream("r37");
    check_status("r37");

    // Long packet WC=6: header plus two payload words, trailing word skipped.
    pkt_target = 8'd0;
    pulse_arm();
    burst_q = '{mk_hdr(6'h39, 2'd0, 16'd6, 8'h5A), 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    run_burst(2);
    check_stream("r38");
    check_status("r38");

    // Data-type filter: 0x05 rejected, 0x39 accepted.
    pulse_abort();
    check("r39.abort_busy", 64'(busy), 64'd0);
    dt_filter_en = 1'b1;
    dt_filter    = 6'h39;
    pulse_arm();
    burst_q = '{mk_hdr(6'h05, 2'd1, 16'h1234, 8'h77)};
    run_burst(2);
    burst_q = '{mk_hdr(6'h39, 2'd2, 16'd2, 8'h11), 32'h0BADF00D};
    run_burst(2);
    check_stream("r39");
    check_status("r39");

    // Truncation: WC=100 but burst ends after 10 payload words.
    dt_filter_en = 1'b0;
    pulse_abort();
    pulse_arm();
    burst_q.push_back(mk_hdr(6'h1E, 2'd3, 16'd100, 8'h42));
    for (int i = 0; i < 10; i++) burst_q.push_back($urandom);
    run_burst(2);
    check_stream("r40");
    check_status("r40");

    // Abort with arm mid-payload, after one counted packet.
    burst_q = '{mk_hdr(6'h12, 2'd0, 16'h0304, 8'h99)};
    run_burst(2);
    check_status("r41.pre");
    burst_q = '{mk_hdr(6'h2C, 2'd1, 16'd20, 8'h3C), 32'h11112222, 32'h33334444, 32'h55556666};
    exp_q.push_back({burst_q[0], 1'b1, 1'b0});
    exp_q.push_back({burst_q[1], 1'b0, 1'b0});
    m_dt = 6'h2C; m_vc = 2'd1; m_wc = 16'd20;
    capture_en = 1'b1;
    set_word(burst_q[0]); step();
    set_word(burst_q[1]); step();
    set_word(burst_q[2]); abort = 1'b1; arm = 1'b1; step();
    abort = 1'b0; arm = 1'b0;
    m_mode = M_IDLE;
    check("r41.busy", 64'(busy), 64'd0);
    set_word(burst_q[3]); step();
    capture_en = 1'b0;
    set_word(32'd0);
    burst_q.delete();
    repeat (2) step();
    check_stream("r41");
    check_status("r41.idle");
    pulse_arm();
    check_status("r41.rearm");

    // Unlimited target: 300 short packets, count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      burst_q = '{mk_hdr(6'h05, 2'($urandom), 16'($urandom), 8'($urandom))};
      run_burst(1);
    end
    step();
    check_stream("r42");
    check_status("r42");

    // Reset in the middle of a long packet: no eop, everything cleared.
    burst_q = '{mk_hdr(6'h39, 2'd0, 16'd40, 8'h01), 32'h01010101, 32'h02020202, 32'h03030303};
    exp_q.push_back({burst_q[0], 1'b1, 1'b0});
    exp_q.push_back({burst_q[1], 1'b0, 1'b0});
    exp_q.push_back({burst_q[2], 1'b0, 1'b0});
    capture_en = 1'b1;
    set_word(burst_q[0]); step();
    set_word(burst_q[1]); step();
    set_word(burst_q[2]); step();
    set_word(burst_q[3]); reset = 1'b1; arm = 1'b1; step();
    reset = 1'b0; arm = 1'b0;
    m_mode = M_IDLE; m_cnt = 0; m_trunc = 1'b0;
    m_dt = '0; m_vc = '0; m_wc = '0;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.out_eop",   64'(out_eop),   64'd0);
    capture_en = 1'b0;
    set_word(32'd0);
    burst_q.delete();
    repeat (2) step();
    check_stream("midrst");
    check_status("midrst");

    // Random bursts: mixed types, lengths, filters and targets.
    for (int it = 0; it < 80; it++) begin
      if (m_mode != M_ARMED) begin
        pkt_target = 8'($urandom_range(0, 4));
        pulse_arm();
      end
      if ($urandom_range(0, 3) == 0) begin
        dt_filter_en = ($urandom_range(0, 2) == 0);
        dt_filter    = dts[$urandom_range(0, 5)];
      end
      dt  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : dts[$urandom_range(0, 5)];
      wc  = 16'($urandom_range(0, 30));
      rem = (int'(wc) + 5) / 4;
      if ($urandom_range(0, 3) == 0) len = 1 + $urandom_range(0, rem - 1);
      else                           len = 1 + rem + $urandom_range(0, 2);
      burst_q.push_back(mk_hdr(dt, 2'($urandom), wc, 8'($urandom)));
      for (int i = 1; i < len; i++) burst_q.push_back($urandom);
      run_burst($urandom_range(2, 3));
      check_stream($sformatf("rnd%0d", it));
      check_status($sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsi_capture_ctrl.md
DSI_CAPTURE_CTRL -- requirements
Module: dsi_capture_ctrl

Interface
REQ-001 SHALL have parameter MAX_PKTS, default 255, meaning the largest legal pkt_target value; the port width is fixed at 8 bits.
REQ-002 SHALL have port clk, input, 1, the single clock, the byte HS clock of the MIPI receiver.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port lane0_data, input, 16, lane 0 byte pair; [7:0] is the earlier byte.
REQ-005 SHALL have port lane1_data, input, 16, lane 1 byte pair; [7:0] is the earlier byte.
REQ-006 SHALL have port capture_en, input, 1, lane data valid; high for the whole HS burst.
REQ-007 SHALL have port arm, input, 1, single-cycle start pulse.
REQ-008 SHALL have port abort, input, 1, single-cycle stop pulse.
REQ-009 SHALL have port dt_filter_en, input, 1, which enables data-type filtering.
REQ-010 SHALL have port dt_filter, input, 6, the data type to accept when filtering is enabled.
REQ-011 SHALL have port pkt_target, input, 8, the number of packets to capture; 0 means unlimited.
REQ-012 SHALL have output ports out_valid (1), out_data (32), out_sop (1) and out_eop (1), forming the gated packet stream.
REQ-013 SHALL have output ports hdr_dt (6), hdr_vc (2) and hdr_wc (16), holding the fields of the last accepted header.
REQ-014 SHALL have output ports busy (1), done (1), trunc_err (1, sticky) and pkt_cnt (8).

Function
REQ-015 SHALL form the stream word W as {lane1_data[15:8], lane0_data[15:8], lane1_data[7:0], lane0_data[7:0]}, so byte0 = W[7:0].
REQ-016 SHALL decode the header from the first burst word (the capture_en 0->1 edge): DI = byte0, DT = DI[5:0], VC = DI[7:6], WC = {byte2, byte1}; ECC (byte3) is passed through unchecked.
REQ-017 SHALL classify a packet as long iff DT[3:0] is one of 9, C, D or E; every other packet is short.
REQ-018 SHALL accept a header iff dt_filter_en = 0, or DT equals dt_filter.
REQ-019 SHALL implement the states IDLE, ARMED, PAYLOAD, SKIP and DONE.
REQ-020 IDLE: on arm SHALL clear pkt_cnt and trunc_err, then go to ARMED.
REQ-021 ARMED: at a burst start with an accepted short header SHALL emit W with sop = eop = 1, increment pkt_cnt and go to SKIP.
REQ-022 ARMED: at a burst start with an accepted long header SHALL emit W with sop = 1, load rem = ceil((WC+2)/4) using 17-bit arithmetic, and go to PAYLOAD.
REQ-023 ARMED: at a burst start with a rejected header SHALL emit nothing and go to SKIP; capture_en already high when entering ARMED SHALL NOT count as a burst start.
REQ-024 PAYLOAD: on each capture_en = 1 cycle SHALL emit W and decrement rem; when rem = 1 it SHALL assert eop, increment pkt_cnt and go to SKIP.
REQ-025 PAYLOAD: if capture_en = 0 while rem > 0, it SHALL set trunc_err, emit nothing, leave pkt_cnt unchanged and go to ARMED.
REQ-026 SKIP: SHALL discard all data; when capture_en = 0 it SHALL go to DONE if pkt_target != 0 and pkt_cnt = pkt_target, otherwise to ARMED.
REQ-027 DONE: SHALL hold done = 1; arm SHALL act exactly as in IDLE.
REQ-028 SHALL ignore arm in ARMED, PAYLOAD and SKIP.
REQ-029 SHALL send any state to IDLE on the next cycle when abort is high, with no eop emitted; abort SHALL win over a simultaneous arm.
REQ-030 SHALL register all stream outputs, giving a latency of exactly 1 clk from the input word to out_valid.
REQ-031 SHALL update hdr_* in the same cycle that out_sop is asserted.
REQ-032 SHALL hold pkt_cnt at 255 (saturate) rather than wrap.
REQ-033 SHALL drive busy = 1 in ARMED, PAYLOAD and SKIP, and 0 otherwise.
REQ-034 SHALL handle only the first packet of each burst; later packets in the same burst fall into SKIP.

Reset
REQ-035 SHALL, while reset is high at a clk edge, set the state to IDLE and drive out_valid, out_sop, out_eop, busy, done and trunc_err to 0, pkt_cnt to 0, out_data to 0 and hdr_* to 0.
REQ-036 SHALL let reset override arm and abort, and a reset in the middle of a packet SHALL produce no eop.

Verification
REQ-037 Arm with pkt_target = 1 and no filter, then a 1-cycle burst of DT 0x05, W = 0x1A000005 -> one cycle later out_valid = sop = eop = 1 and out_data = 0x1A000005; done = 1 after capture_en falls.
REQ-038 A long packet with DT 0x39 and WC = 6 -> rem = 2; exactly 3 out_valid cycles, sop on the first, eop on the third; hdr_wc = 6.
REQ-039 dt_filter_en = 1, dt_filter = 0x39, then bursts of DT 0x05 followed by DT 0x39 -> only the 0x39 packet is emitted and pkt_cnt = 1.
REQ-040 Long packet with WC = 100 and capture_en dropped after 10 payload words -> trunc_err = 1, no eop, pkt_cnt = 0, state ARMED.
REQ-041 abort together with arm during PAYLOAD -> IDLE next cycle with busy = 0; a later arm clears trunc_err and pkt_cnt.
REQ-042 pkt_target = 0 with 300 short packets -> done stays 0 and pkt_cnt saturates at 255.
